// File: rtl/frame_pkg.sv
// Shared constants, cell codes and update bundle for the frame tracker.
// Defaults describe the 16x12 playfield with four object layers.
package frame_pkg;

  localparam int GRID_W_DEF  = 16;
  localparam int GRID_H_DEF  = 12;
  localparam int NUM_OBJ_DEF = 4;
  localparam int CODE_W_DEF  = 3;

  localparam int CODE_EMPTY  = 0;
  localparam int CODE_BORDER = 1;
  localparam int CODE_HEAD   = 2;
  localparam int CODE_BODY   = 3;
  localparam int CODE_APPLE  = 4;

  typedef struct packed {
    logic [$clog2(GRID_W_DEF)-1:0] x;
    logic [$clog2(GRID_H_DEF)-1:0] y;
    logic [CODE_W_DEF-1:0]         code;
  } upd_t;

endpackage

// File: rtl/obj_prio_enc.sv
// Priority encoder: obj_hit -> cell code, index 0 wins, code = index+1.
// Ports: obj_hit (NUM_OBJ) in, code (CODE_W) out; no hit gives empty.
module obj_prio_enc
  import frame_pkg::*;
#(
  parameter int NUM_OBJ = NUM_OBJ_DEF,
  parameter int CODE_W  = CODE_W_DEF
) (
  input  logic [NUM_OBJ-1:0] obj_hit,
  output logic [CODE_W-1:0]  code
);

  // Walk from the lowest priority up so the highest one lands last.
  always_comb begin
    code = CODE_W'(CODE_EMPTY);
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (obj_hit[i]) code = CODE_W'(i + 1);
    end
  end

endmodule

// File: rtl/frame_diff_tracker.sv
// Raster grid tracker: stores a code per cell, streams changed cells.
// Ports: clk/nrst, scan_en, obj_hit, force_redraw, cursor, upd_* stream,
// frame_done pulse and last_changes count of the previous frame.
module frame_diff_tracker
  import frame_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int NUM_OBJ = NUM_OBJ_DEF,
  parameter int CODE_W  = CODE_W_DEF,
  parameter int XW      = $clog2(GRID_W),
  parameter int YW      = $clog2(GRID_H),
  parameter int CW      = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               scan_en,
  input  logic [NUM_OBJ-1:0] obj_hit,
  input  logic               force_redraw,
  output logic [XW-1:0]      cur_x,
  output logic [YW-1:0]      cur_y,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [XW-1:0]      upd_x,
  output logic [YW-1:0]      upd_y,
  output logic [CODE_W-1:0]  upd_code,
  output logic               frame_done,
  output logic [CW-1:0]      last_changes
);

  logic [CODE_W-1:0] new_code;
  logic [CODE_W-1:0] grid [GRID_H][GRID_W];
  logic [CW-1:0]     chg_cnt;
  logic              redraw_pending;
  logic              redraw_active;
  logic              stall;
  logic              step;
  logic              x_end;
  logic              at_end;
  logic              at_org;
  logic              redraw_eff;
  logic              changed;

  obj_prio_enc #(
    .NUM_OBJ(NUM_OBJ),
    .CODE_W (CODE_W)
  ) u_enc (
    .obj_hit(obj_hit),
    .code   (new_code)
  );

  assign stall  = upd_valid & ~upd_ready;
  assign step   = scan_en & ~stall;
  assign x_end  = cur_x == XW'(GRID_W - 1);
  assign at_end = x_end & (cur_y == YW'(GRID_H - 1));
  assign at_org = (cur_x == '0) & (cur_y == '0);

  // The origin step of a redraw frame must already count as redrawn,
  // before redraw_active itself has been registered.
  assign redraw_eff = redraw_active | (at_org & redraw_pending);
  assign changed    = (new_code != grid[cur_y][cur_x]) | redraw_eff;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int y = 0; y < GRID_H; y++) begin
        for (int x = 0; x < GRID_W; x++) begin
          grid[y][x] <= CODE_W'(CODE_EMPTY);
        end
      end
    end else if (step) begin
      grid[cur_y][cur_x] <= new_code;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_x        <= '0;
      cur_y        <= '0;
      chg_cnt      <= '0;
      last_changes <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= step & at_end;
      if (step) begin
        if (x_end) begin
          cur_x <= '0;
          cur_y <= at_end ? '0 : cur_y + 1'b1;
        end else begin
          cur_x <= cur_x + 1'b1;
        end
        if (at_end) begin
          chg_cnt      <= '0;
          last_changes <= chg_cnt + CW'(changed);
        end else begin
          chg_cnt <= chg_cnt + CW'(changed);
        end
      end
    end
  end

  // A pulse that coincides with the origin step re-arms pending, so it
  // applies to the following frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      redraw_pending <= 1'b0;
      redraw_active  <= 1'b0;
    end else begin
      redraw_pending <= force_redraw
                      | (redraw_pending & ~(step & at_org));
      if (step & at_end) begin
        redraw_active <= 1'b0;
      end else if (step & at_org & redraw_pending) begin
        redraw_active <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      upd_valid <= 1'b0;
      upd_x     <= '0;
      upd_y     <= '0;
      upd_code  <= '0;
    end else if (step & changed) begin
      upd_valid <= 1'b1;
      upd_x     <= cur_x;
      upd_y     <= cur_y;
      upd_code  <= new_code;
    end else if (upd_ready) begin
      upd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_diff_tracker.sv
// Self-checking bench for frame_diff_tracker against a grid model.
// Random and directed frames, backpressure, redraw and mid-frame reset.
module tb_frame_diff_tracker;
  import frame_pkg::*;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int N  = 4;
  localparam int C  = 3;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          scan_en = 1'b0;
  logic [N-1:0]  obj_hit = '0;
  logic          force_redraw = 1'b0;
  logic          upd_ready = 1'b1;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          upd_valid;
  logic [XW-1:0] upd_x;
  logic [YW-1:0] upd_y;
  logic [C-1:0]  upd_code;
  logic          frame_done;
  logic [CW-1:0] last_changes;
  logic [28:0]   dut_vec;

  always #5 clk = ~clk;

  frame_diff_tracker dut (
    .clk         (clk),
    .nrst        (nrst),
    .scan_en     (scan_en),
    .obj_hit     (obj_hit),
    .force_redraw(force_redraw),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .upd_code    (upd_code),
    .frame_done  (frame_done),
    .last_changes(last_changes)
  );

  assign dut_vec = {cur_x, cur_y, upd_valid, upd_x, upd_y, upd_code,
                    frame_done, last_changes};

  int vectors  = 0;
  int errors   = 0;
  int accepted = 0;

  // Reference model: whole grid as an array, cursor as plain integers.
  int     mg [H][W];
  int     mx, my, mcnt, mlast, mloads;
  bit     mpend, mact, mvalid, mdone;
  upd_t   mu;

  function automatic logic [28:0] model_vec();
    return {4'(mx), 4'(my), mvalid, mu.x, mu.y, mu.code,
            mdone, 8'(mlast)};
  endfunction

  function automatic int enc(logic [N-1:0] h);
    for (int i = 0; i < N; i++) if (h[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [N-1:0] pat(int mode, int x, int y);
    case (mode)
      1: return ((x == 0 && y == 0) || (x == W-1 && y == H-1))
                ? 4'b0001 : 4'b0000;
      2: return (x == 3 && y == 2) ? 4'b1010 : 4'b0000;
      3: return ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mg[y][x] = 0;
    mx = 0; my = 0; mcnt = 0; mlast = 0;
    mpend = 0; mact = 0; mvalid = 0; mdone = 0;
    mu = '0;
  endtask

  // Apply one clock with the given hit pattern; advance the model.
  task automatic tick(input int mode);
    bit step, org, last, eff;
    int code;
    obj_hit = pat(mode, mx, my);
    if (upd_valid && upd_ready) accepted++;
    step = scan_en && !(mvalid && !upd_ready);
    org  = (mx == 0 && my == 0);
    last = (mx == W-1 && my == H-1);
    eff  = mact || (org && mpend);
    if (mvalid && upd_ready) mvalid = 0;
    mdone = 0;
    if (step) begin
      code = enc(obj_hit);
      if (code != mg[my][mx] || eff) begin
        mvalid = 1;
        mu.x = 4'(mx); mu.y = 4'(my); mu.code = 3'(code);
        mcnt++; mloads++;
      end
      mg[my][mx] = code;
      if (org && mpend) mact = 1;
      if (last) begin
        mlast = mcnt; mcnt = 0; mdone = 1; mact = 0;
      end
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    mpend = force_redraw || (mpend && !(step && org));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    mloads = 0;
    #2;
    vectors++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, model_vec());
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_empty_frame();
    scan_en = 1; upd_ready = 1;
    for (int i = 0; i < W*H; i++) begin
      tick(0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL empty_frame i=%0d got=%h exp=%h",
                 i, dut_vec, model_vec());
      end
    end
    vectors++;
    if (frame_done !== 1'b1 || last_changes !== 8'd0) begin
      errors++;
      $display("FAIL empty_done got=%b/%0d exp=1/0",
               frame_done, last_changes);
    end
  endtask

  task automatic test_corners();
    int a0, lc[2];
    a0 = accepted;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W*H; i++) begin
        tick(1);
        vectors++;
        if (dut_vec !== model_vec()) begin
          errors++;
          $display("FAIL corners f=%0d i=%0d got=%h exp=%h",
                   f, i, dut_vec, model_vec());
        end
      end
      lc[f] = int'(last_changes);
      vectors++;
      if (frame_done !== 1'b1 || lc[f] != (f == 0 ? 2 : 0)) begin
        errors++;
        $display("FAIL corners_count f=%0d got=%b/%0d exp=1/%0d",
                 f, frame_done, lc[f], f == 0 ? 2 : 0);
      end
    end
    vectors++;
    if (accepted - a0 != 2) begin
      errors++;
      $display("FAIL corners_accepted got=%0d exp=2", accepted - a0);
    end
  endtask

  task automatic test_priority();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W*H; i++) begin
        tick(f == 0 ? 2 : 0);
        vectors++;
        if (dut_vec !== model_vec()) begin
          errors++;
          $display("FAIL priority f=%0d i=%0d got=%h exp=%h",
                   f, i, dut_vec, model_vec());
        end
        if (i == 2*W + 3) begin
          vectors++;
          if (upd_valid !== 1'b1 || upd_x !== 4'd3 || upd_y !== 4'd2
              || upd_code !== (f == 0 ? 3'd2 : 3'd0)) begin
            errors++;
            $display("FAIL priority_cell f=%0d got=%b(%0d,%0d,%0d)",
                     f, upd_valid, upd_x, upd_y, upd_code);
          end
        end
      end
      vectors++;
      if (last_changes !== (f == 0 ? 8'd3 : 8'd1)) begin
        errors++;
        $display("FAIL priority_count f=%0d got=%0d exp=%0d",
                 f, last_changes, f == 0 ? 3 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int a0, l0, sx, sy;
    bit seen, back;
    upd_t su;
    a0 = accepted; l0 = mloads; seen = 0; back = 0;
    scan_en = 1; upd_ready = 1;
    for (int k = 0; k < W*H && !seen; k++) begin
      tick(3);
      vectors++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL bp_pre k=%0d got=%h exp=%h",
                 k, dut_vec, model_vec());
      end
      seen = upd_valid;
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_first_update got=none exp=valid");
    end
    sx = mx; sy = my; su = mu;
    upd_ready = 0;
    for (int k = 0; k < 10; k++) begin
      tick(3);
      vectors++;
      if ({cur_x, cur_y, upd_valid, upd_x, upd_y, upd_code} !==
          {4'(sx), 4'(sy), 1'b1, su.x, su.y, su.code}) begin
        errors++;
        $display("FAIL bp_hold k=%0d got=%h exp=%h", k,
                 {cur_x, cur_y, upd_valid, upd_x, upd_y, upd_code},
                 {4'(sx), 4'(sy), 1'b1, su.x, su.y, su.code});
      end
    end
    for (int k = 0; k < 3000 && !back; k++) begin
      upd_ready = 1'($urandom);
      tick(3);
      vectors++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL bp_rand k=%0d got=%h exp=%h",
                 k, dut_vec, model_vec());
      end
      back = (mx == 0 && my == 0);
    end
    vectors++;
    if (!back) begin
      errors++;
      $display("FAIL bp_wrap got=timeout exp=frame_end");
    end
    scan_en = 0; upd_ready = 1;
    tick(0);
    tick(0);
    vectors++;
    if (accepted - a0 != mloads - l0 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_loss got=%0d exp=%0d",
               accepted - a0, mloads - l0);
    end
  endtask

  task automatic test_redraw();
    int exp_lc[6] = '{-1, 0, 192, 0, 192, 0};
    scan_en = 1; upd_ready = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < W*H; i++) begin
        force_redraw = (f == 1 && i == 50) || (f == 3 && i == 0);
        tick(0);
        vectors++;
        if (dut_vec !== model_vec()) begin
          errors++;
          $display("FAIL redraw f=%0d i=%0d got=%h exp=%h",
                   f, i, dut_vec, model_vec());
        end
      end
      force_redraw = 0;
      if (exp_lc[f] >= 0) begin
        vectors++;
        if (int'(last_changes) != exp_lc[f]) begin
          errors++;
          $display("FAIL redraw_count f=%0d got=%0d exp=%0d",
                   f, last_changes, exp_lc[f]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    scan_en = 1; upd_ready = 1;
    for (int i = 0; i < W*H; i++) tick(1);
    vectors++;
    if (last_changes !== 8'd2) begin
      errors++;
      $display("FAIL rst_pre_count got=%0d exp=2", last_changes);
    end
    tick(0);
    upd_ready = 0;
    for (int i = 0; i < 5; i++) tick(3);
    vectors++;
    if (upd_valid !== 1'b1 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL rst_pre_state got=%h exp=%h", dut_vec, model_vec());
    end
    #2 nrst = 0;
    #1;
    model_reset();
    vectors++;
    if (upd_valid !== 1'b0 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL rst_mid got=%h exp=%h", dut_vec, model_vec());
    end
    @(negedge clk);
    nrst = 1; upd_ready = 1;
    for (int i = 0; i < W*H; i++) begin
      tick(1);
      vectors++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL rst_post i=%0d got=%h exp=%h",
                 i, dut_vec, model_vec());
      end
    end
    vectors++;
    if (last_changes !== 8'd2) begin
      errors++;
      $display("FAIL rst_post_count got=%0d exp=2", last_changes);
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_corners();
    test_priority();
    test_backpressure();
    test_redraw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
